axi_lite_bus_arbiter: RTL and testbench

Shares the core's single AXI-Lite master port between two requesters: instruction fetch (read-only) and the MEM stage (read/write with byte strobes).
- Sequences each access as one AXI-Lite transaction and returns data plus a one-cycle ack.
- Raises per-requester stall requests into CTRL, so the pipeline freezes while an access is outstanding.
- Sits between core and SoC interconnect; replaces the direct rom_addr_o/rom_ce_o/rom_data_i path.

---
 rtl/axi_lite_bus_arbiter_pkg.sv | 20 ++
 rtl/axi_lite_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi_lite_bus_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_bus_arbiter_pkg.sv
// Shared types for the AXI-Lite bus arbiter: FSM states, grant owner, response codes.
package axi_lite_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_lite_bus_arbiter.sv
// Shares one AXI-Lite master port between instruction fetch and the MEM stage.
// Each request becomes exactly one AXI-Lite transaction, completed by a one-cycle ack.
//
// Handshakes: every AXI channel transfers on a cycle where valid & ready are both
// high at the rising edge; a valid, once raised, stays high with stable payload until
// that transfer. The requester side holds req and its payload until its ack pulse.
module axi_lite_bus_arbiter
    import axi_lite_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req_i,
    input  logic [ADDR_W-1:0]   inst_addr_i,
    output logic [DATA_W-1:0]   inst_rdata_o,
    output logic                inst_ack_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    input  logic [DATA_W/8-1:0] data_sel_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_ack_o,
    output logic                if_stall_req_o,
    output logic                mem_stall_req_o,
    output logic                bus_err_o,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output state_t              dbg_state_o,
    output grant_t              dbg_grant_o,
    output logic                dbg_starve_o
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state_q, state_d;
    grant_t              grant_q, grant_d;
    logic                starve_q, starve_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic                awvalid_q, awvalid_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                inst_ack_q, inst_ack_d;
    logic                data_ack_q, data_ack_d;
    logic                bus_err_q, bus_err_d;

    logic pick_data;
    logic contested;
    logic aw_done;
    logic w_done;

    // Next-state logic: arbitration, payload latching and AXI channel sequencing.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        starve_d     = starve_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        awvalid_d    = awvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        bus_err_d    = 1'b0;

        // The favoured side wins a contest unless the other side lost the previous one.
        contested = inst_req_i & data_req_i;
        pick_data = data_req_i & (~inst_req_i | (DATA_FIRST ? ~starve_q : starve_q));
        // A write address/data channel counts as done once its valid is gone or transfers now.
        aw_done   = ~awvalid_q | m_awready;
        w_done    = ~wvalid_q | m_wready;

        unique case (state_q)
            ST_IDLE: begin
                if (inst_req_i | data_req_i) begin
                    if (contested) begin
                        starve_d = ~starve_q;
                    end else if (pick_data != DATA_FIRST) begin
                        starve_d = 1'b0;
                    end
                    if (pick_data) begin
                        grant_d = GNT_DATA;
                        if (data_we_i) begin
                            awaddr_d  = data_addr_i;
                            wdata_d   = data_wdata_i;
                            wstrb_d   = data_sel_i;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            state_d   = ST_WR_ADDR;
                        end else begin
                            araddr_d  = data_addr_i;
                            arvalid_d = 1'b1;
                            state_d   = ST_RD_ADDR;
                        end
                    end else begin
                        grant_d   = GNT_INST;
                        araddr_d  = inst_addr_i;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_rvalid) begin
                    rready_d  = 1'b0;
                    bus_err_d = (m_rresp != AXI_RESP_OKAY);
                    if (grant_q == GNT_DATA) begin
                        data_rdata_d = m_rdata;
                        data_ack_d   = 1'b1;
                    end else begin
                        inst_rdata_d = m_rdata;
                        inst_ack_d   = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_WR_ADDR: begin
                if (awvalid_q & m_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q & m_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done & w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid) begin
                    bready_d   = 1'b0;
                    bus_err_d  = (m_bresp != AXI_RESP_OKAY);
                    data_ack_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                // Ack is visible this cycle; IDLE samples requests only from the next one.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_INST;
            starve_q     <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            awvalid_q    <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            starve_q     <= starve_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            awvalid_q    <= awvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign inst_rdata_o    = inst_rdata_q;
    assign inst_ack_o      = inst_ack_q;
    assign data_rdata_o    = data_rdata_q;
    assign data_ack_o      = data_ack_q;
    assign bus_err_o       = bus_err_q;
    assign if_stall_req_o  = inst_req_i & ~inst_ack_q;
    assign mem_stall_req_o = data_req_i & ~data_ack_q;
    assign m_araddr        = araddr_q;
    assign m_arvalid       = arvalid_q;
    assign m_rready        = rready_q;
    assign m_awaddr        = awaddr_q;
    assign m_awvalid       = awvalid_q;
    assign m_wdata         = wdata_q;
    assign m_wstrb         = wstrb_q;
    assign m_wvalid        = wvalid_q;
    assign m_bready        = bready_q;
    assign dbg_state_o     = state_q;
    assign dbg_grant_o     = grant_q;
    assign dbg_starve_o    = starve_q;

endmodule

// File: tb/tb_axi_lite_bus_arbiter.sv
// Directed bench for axi_lite_bus_arbiter: a vector table of single transactions
// against a delay-configurable AXI-Lite slave, plus arbitration, reset-abort and
// address-hold sequences.
module tb_axi_lite_bus_arbiter;
    import axi_lite_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_rdata_o;
    logic        inst_ack_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [3:0]  data_sel_i = '0;
    logic [31:0] data_rdata_o;
    logic        data_ack_o;
    logic        if_stall_req_o, mem_stall_req_o, bus_err_o;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    state_t      dbg_state;
    grant_t      dbg_grant;
    logic        dbg_starve;

    axi_lite_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_rdata_o(inst_rdata_o),
        .inst_ack_o(inst_ack_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_sel_i(data_sel_i), .data_rdata_o(data_rdata_o),
        .data_ack_o(data_ack_o),
        .if_stall_req_o(if_stall_req_o), .mem_stall_req_o(mem_stall_req_o), .bus_err_o(bus_err_o),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .dbg_state_o(dbg_state), .dbg_grant_o(dbg_grant), .dbg_starve_o(dbg_starve)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    int          ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0, b_wait = 0;
    logic [31:0] slv_rdata = '0;
    logic [1:0]  slv_resp = '0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    logic        r_pend = 1'b0, b_pend = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
    int          ar_hs_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0;
    logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic        aw_now, w_now;

    assign aw_now = m_awvalid & m_awready;
    assign w_now  = m_wvalid & m_wready;

    // Observe transfers at the active edge; the slave resets with the DUT.
    always @(posedge clk) begin
        if (rst) begin
            r_pend  <= 1'b0;
            b_pend  <= 1'b0;
            aw_seen <= 1'b0;
            w_seen  <= 1'b0;
        end else begin
            if (m_arvalid && m_arready) begin
                ar_hs_cnt  <= ar_hs_cnt + 1;
                cap_araddr <= m_araddr;
                r_pend     <= 1'b1;
            end
            if (m_rvalid && m_rready) r_pend <= 1'b0;
            if (aw_now) begin
                aw_hs_cnt  <= aw_hs_cnt + 1;
                cap_awaddr <= m_awaddr;
            end
            if (w_now) begin
                w_hs_cnt  <= w_hs_cnt + 1;
                cap_wdata <= m_wdata;
                cap_wstrb <= m_wstrb;
            end
            if ((aw_now || aw_seen) && (w_now || w_seen) && (aw_now || w_now)) begin
                b_pend  <= 1'b1;
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
            end else begin
                if (aw_now) aw_seen <= 1'b1;
                if (w_now)  w_seen  <= 1'b1;
            end
            if (m_bvalid && m_bready) b_pend <= 1'b0;
        end
    end

    // Drive slave responses on the falling edge after the programmed wait.
    always @(negedge clk) begin
        m_arready = m_arvalid && (ar_cnt >= ar_wait);
        ar_cnt    = m_arvalid ? ar_cnt + 1 : 0;
        m_awready = m_awvalid && (aw_cnt >= aw_wait);
        aw_cnt    = m_awvalid ? aw_cnt + 1 : 0;
        m_wready  = m_wvalid && (w_cnt >= w_wait);
        w_cnt     = m_wvalid ? w_cnt + 1 : 0;
        m_rvalid  = r_pend && (r_cnt >= r_wait);
        r_cnt     = r_pend ? r_cnt + 1 : 0;
        m_bvalid  = b_pend && (b_cnt >= b_wait);
        b_cnt     = b_pend ? b_cnt + 1 : 0;
        m_rdata   = slv_rdata;
        m_rresp   = slv_resp;
        m_bresp   = slv_resp;
    end

    // ---------------- scoreboard / checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] slv_rdata;
        logic [1:0]  resp;
        int          ar_w, r_w, aw_w, w_w, b_w;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    // ---------------- driver ----------------
    task automatic run_txn(input vec_t v, output logic [31:0] rdata, output logic err,
                           output int lat);
        logic done, ack, stall;
        int   stall_bad;
        ar_wait   = v.ar_w;
        r_wait    = v.r_w;
        aw_wait   = v.aw_w;
        w_wait    = v.w_w;
        b_wait    = v.b_w;
        slv_rdata = v.slv_rdata;
        slv_resp  = v.resp;
        if (v.is_data) begin
            data_req_i   = 1'b1;
            data_we_i    = v.we;
            data_addr_i  = v.addr;
            data_wdata_i = v.wdata;
            data_sel_i   = v.sel;
        end else begin
            inst_req_i  = 1'b1;
            inst_addr_i = v.addr;
        end
        lat = 0; done = 1'b0; stall_bad = 0; rdata = '0; err = 1'b0;
        while (!done && lat < 60) begin
            #1;
            ack   = v.is_data ? data_ack_o : inst_ack_o;
            stall = v.is_data ? mem_stall_req_o : if_stall_req_o;
            if (ack) begin
                done  = 1'b1;
                rdata = v.is_data ? data_rdata_o : inst_rdata_o;
                err   = bus_err_o;
                check("stall_in_ack", 32'(stall), 32'd0);
            end else begin
                if (stall !== 1'b1) stall_bad++;
                @(negedge clk);
                lat++;
            end
        end
        check("ack_seen", 32'(done), 32'd1);
        check("stall_while_busy", 32'(stall_bad), 32'd0);
        inst_req_i = 1'b0;
        data_req_i = 1'b0;
    endtask

    // ---------------- test ----------------
    vec_t        vecs[7];
    vec_t        v;
    logic [31:0] rd, exp_inst_rdata, exp_data_rdata;
    logic        er;
    int          lat, ar0, aw0, w0, grants, cyc, bad;
    logic [0:0]  got, want;

    initial begin
        vecs[0] = '{0, 0, 32'h0000_0040, 32'h0, 4'h0, 32'h2408_0001, 2'b00, 0, 0, 0, 0, 0, 32'h2408_0001, 0, 3};
        vecs[1] = '{1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2'b00, 0, 0, 0, 2, 0, 32'h0, 0, 5};
        vecs[2] = '{1, 0, 32'h0000_2004, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1, 2, 0, 0, 0, 32'h1234_5678, 0, 6};
        vecs[3] = '{1, 0, 32'h0000_3000, 32'h0, 4'h0, 32'hBAD0_BAD0, 2'b10, 0, 0, 0, 0, 0, 32'hBAD0_BAD0, 1, 3};
        vecs[4] = '{1, 1, 32'h0000_3004, 32'h0102_0304, 4'b1111, 32'h0, 2'b11, 0, 0, 0, 0, 1, 32'h0, 1, 4};
        vecs[5] = '{0, 0, 32'h0000_0044, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 2, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 5};
        vecs[6] = '{1, 1, 32'h0000_1008, 32'h5555_AAAA, 4'b1100, 32'h0, 2'b00, 0, 0, 3, 0, 0, 32'h0, 0, 6};

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_valids", 32'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 32'd0);
        check("rst_acks", 32'({inst_ack_o, data_ack_o, bus_err_o}), 32'd0);
        check("rst_inst_rdata", inst_rdata_o, 32'd0);
        check("rst_data_rdata", data_rdata_o, 32'd0);
        check("rst_araddr", m_araddr, 32'd0);
        check("rst_awaddr", m_awaddr, 32'd0);
        check("rst_starve", 32'(dbg_starve), 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        exp_inst_rdata = '0;
        exp_data_rdata = '0;

        // ---- vector table: single transactions ----
        for (int i = 0; i < 7; i++) begin
            v   = vecs[i];
            ar0 = ar_hs_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt;
            run_txn(v, rd, er, lat);
            check("latency", 32'(lat), 32'(v.exp_lat));
            check("bus_err", 32'(er), 32'(v.exp_err));
            if (!v.we) begin
                check("rdata", rd, v.exp_rdata);
                check("araddr", cap_araddr, v.addr);
                if (v.is_data) exp_data_rdata = v.exp_rdata;
                else           exp_inst_rdata = v.exp_rdata;
            end else begin
                check("awaddr", cap_awaddr, v.addr);
                check("wdata", cap_wdata, v.wdata);
                check("wstrb", 32'(cap_wstrb), 32'(v.sel));
            end
            check("ar_handshakes", 32'(ar_hs_cnt - ar0), 32'(!v.we));
            check("aw_handshakes", 32'(aw_hs_cnt - aw0), 32'(v.we));
            check("w_handshakes", 32'(w_hs_cnt - w0), 32'(v.we));
            @(negedge clk); #1;
            check("ack_one_cycle", 32'({inst_ack_o, data_ack_o, bus_err_o}), 32'd0);
            check("back_to_idle", 32'(dbg_state), 32'(ST_IDLE));
            check("inst_rdata_hold", inst_rdata_o, exp_inst_rdata);
            check("data_rdata_hold", data_rdata_o, exp_data_rdata);
        end

        // ---- both requesters every cycle: alternate D, I, D, I, D, I ----
        ar_wait = 0; r_wait = 0; slv_resp = 2'b00; slv_rdata = 32'h0;
        exp_q = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        inst_req_i = 1'b1; inst_addr_i = 32'h0000_0100;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0200;
        grants = 0; cyc = 0;
        while (grants < 6 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
            if (data_ack_o || inst_ack_o) begin
                got  = data_ack_o;
                want = exp_q.pop_front();
                check("grant_order", 32'(got), 32'(want));
                check("single_ack", 32'(data_ack_o & inst_ack_o), 32'd0);
                check("grant_addr", cap_araddr, want ? 32'h0000_0200 : 32'h0000_0100);
                check("starve_flag", 32'(dbg_starve), 32'(want));
                grants++;
                if (grants == 6) begin
                    inst_req_i = 1'b0;
                    data_req_i = 1'b0;
                end
            end
        end
        check("arb_grants", 32'(grants), 32'd6);
        inst_req_i = 1'b0;
        data_req_i = 1'b0;
        @(negedge clk); #1;

        // ---- reset while waiting in RD_DATA ----
        r_wait = 20; slv_rdata = 32'h7777_0000;
        inst_req_i = 1'b1; inst_addr_i = 32'h0000_0080;
        cyc = 0;
        while (dbg_state != ST_RD_DATA && cyc < 20) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("reach_rd_data", 32'(dbg_state), 32'(ST_RD_DATA));
        rst = 1'b1;
        inst_req_i = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_valids", 32'({m_arvalid, m_rready, inst_ack_o, data_ack_o}), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_mid_rdata", inst_rdata_o, 32'd0);
        rst = 1'b0;
        r_wait = 0;
        @(negedge clk); #1;
        v = '{0, 0, 32'h0000_0084, 32'h0, 4'h0, 32'h1357_9BDF, 2'b00, 0, 0, 0, 0, 0, 32'h1357_9BDF, 0, 3};
        run_txn(v, rd, er, lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_rdata", rd, 32'h1357_9BDF);
        check("post_rst_araddr", cap_araddr, 32'h0000_0084);
        @(negedge clk); #1;

        // ---- requester changes address after it was sampled ----
        ar_wait = 3; r_wait = 0; slv_rdata = 32'h0A0A_0A0A; slv_resp = 2'b00;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_1000;
        @(negedge clk); #1;
        data_addr_i = 32'h0000_2000;
        bad = 0; cyc = 0;
        while (!data_ack_o && cyc < 30) begin
            if (m_araddr !== 32'h0000_1000) bad++;
            @(negedge clk); #1;
            cyc++;
        end
        check("addr_hold_cycles", 32'(bad), 32'd0);
        check("addr_hold_ack", 32'(data_ack_o), 32'd1);
        check("addr_hold_hs", cap_araddr, 32'h0000_1000);
        check("addr_hold_rdata", data_rdata_o, 32'h0A0A_0A0A);
        data_req_i = 1'b0;
        @(negedge clk); #1;
        check("addr_hold_idle", 32'(dbg_state), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Backstop so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
